// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared constants, edge-mode enum and clog2 helper for the PIO bank
// Contents:
//   REG_OUT/REG_IN/REG_EDGE/REG_MASK : per-channel register offsets (address bits [1:0])
//   edge_mode_e                      : capture condition selector
//   clog2                            : ceiling log2, used to size the channel address field
package pio_pkg;

  localparam logic [1:0] REG_OUT  = 2'd0;
  localparam logic [1:0] REG_IN   = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_MASK = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_mode_e;

  // clog2(1) = 0, so a single-channel bank needs only the two register bits.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// rtl/pio_sync_edge.sv - per-channel input synchroniser and edge detector
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : asynchronous input bits
//   sync_val   : synchronised value (second flop)
//   det        : one-cycle pulse per bit meeting the EDGE_MODE condition
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int EDGE_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sync_val,
  output logic [DATA_W-1:0] det
);

  logic [DATA_W-1:0] s1;
  logic [DATA_W-1:0] s2;
  logic [DATA_W-1:0] s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync_val = s2;

  // s3 is the previous synchronised value; comparing it with s2 gives the edge.
  generate
    if (EDGE_MODE == int'(EDGE_FALL)) begin : g_fall
      assign det = ~s2 & s3;
    end else if (EDGE_MODE == int'(EDGE_ANY)) begin : g_any
      assign det = s2 ^ s3;
    end else begin : g_rise
      assign det = s2 & ~s3;
    end
  endgenerate

endmodule

// File: rtl/avalon_pio_bank.sv
// rtl/avalon_pio_bank.sv - Avalon-MM bank of NUM_CH PIO channels with edge capture and irq
// Ports:
//   clk_clk, reset_reset_n : clock, asynchronous active-low reset
//   avs_*                  : Avalon-MM slave, word address {channel, reg}, read latency 1
//   pio_out                : OUT registers, channel c at [c*DATA_W +: DATA_W]
//   pio_in                 : asynchronous inputs, same packing
//   irq                    : registered OR of EDGE & MASK over all channels
module avalon_pio_bank
  import pio_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          DATA_W    = 32,
  parameter int          EDGE_MODE = 0,
  parameter logic [31:0] OUT_RESET = 32'h0,
  parameter int          ADDR_W    = clog2(NUM_CH) + 2
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic [ADDR_W-1:0]        avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata,
  input  logic [3:0]               avs_byteenable,
  output logic [31:0]              avs_readdata,
  output logic [NUM_CH*DATA_W-1:0] pio_out,
  input  logic [NUM_CH*DATA_W-1:0] pio_in,
  output logic                     irq
);

  logic [DATA_W-1:0] out_q    [NUM_CH];
  logic [DATA_W-1:0] edge_q   [NUM_CH];
  logic [DATA_W-1:0] mask_q   [NUM_CH];
  logic [DATA_W-1:0] sync_val [NUM_CH];
  logic [DATA_W-1:0] det      [NUM_CH];

  logic [31:0]       addr_ch;
  logic [1:0]        reg_sel;
  logic [31:0]       be_mask;
  logic [DATA_W-1:0] be_bits;
  logic [DATA_W-1:0] wr_bits;
  logic [NUM_CH-1:0] wr_hit;
  logic [31:0]       rd_val;
  logic              irq_any;

  genvar gc;
  generate
    for (gc = 0; gc < NUM_CH; gc++) begin : g_ch
      pio_sync_edge #(
        .DATA_W   (DATA_W),
        .EDGE_MODE(EDGE_MODE)
      ) u_sync (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .din     (pio_in[gc*DATA_W +: DATA_W]),
        .sync_val(sync_val[gc]),
        .det     (det[gc])
      );
      assign pio_out[gc*DATA_W +: DATA_W] = out_q[gc];
    end
  endgenerate

  // Channel field is compared as a full integer so an address beyond NUM_CH
  // (non power-of-two bank) simply matches no channel.
  always_comb begin
    addr_ch = 32'(avs_address) >> 2;
    reg_sel = avs_address[1:0];
    be_mask = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
               {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
    be_bits = be_mask[DATA_W-1:0];
    wr_bits = avs_writedata[DATA_W-1:0] & be_bits;
    wr_hit  = '0;
    rd_val  = '0;
    irq_any = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c] = avs_write && (addr_ch == 32'(c));
      irq_any   = irq_any | (|(edge_q[c] & mask_q[c]));
      if (addr_ch == 32'(c)) begin
        case (reg_sel)
          REG_OUT:  rd_val[DATA_W-1:0] = out_q[c];
          REG_IN:   rd_val[DATA_W-1:0] = sync_val[c];
          REG_EDGE: rd_val[DATA_W-1:0] = edge_q[c];
          default:  rd_val[DATA_W-1:0] = mask_q[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        out_q[c]  <= OUT_RESET[DATA_W-1:0];
        edge_q[c] <= '0;
        mask_q[c] <= '0;
      end
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_hit[c] && reg_sel == REG_OUT)
          out_q[c] <= (out_q[c] & ~be_bits) | wr_bits;
        if (wr_hit[c] && reg_sel == REG_MASK)
          mask_q[c] <= (mask_q[c] & ~be_bits) | wr_bits;
        // Detection is OR-ed after the clear so a same-cycle edge survives W1C.
        edge_q[c] <= (edge_q[c] & ~((wr_hit[c] && reg_sel == REG_EDGE) ? wr_bits : '0))
                     | det[c];
      end
      // rd_val reflects pre-write register contents, giving read-before-write.
      if (avs_read)
        avs_readdata <= rd_val;
      irq <= irq_any;
    end
  end

endmodule

// File: tb/tb_avalon_pio_bank.sv
// tb/tb_avalon_pio_bank.sv - self-checking bench for avalon_pio_bank (two configurations)
module tb_avalon_pio_bank;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   addr_a, addr_b;
  logic         rd_a, wr_a, rd_b, wr_b;
  logic [31:0]  wd_a, wd_b;
  logic [3:0]   be_a, be_b;
  logic [31:0]  rdd_a, rdd_b;
  logic [127:0] pout_a, pin_a;
  logic [35:0]  pout_b, pin_b;
  logic         irq_a, irq_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  avalon_pio_bank #(.NUM_CH(4), .DATA_W(32), .EDGE_MODE(0), .OUT_RESET(32'h0000_00FF)) dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(addr_a), .avs_read(rd_a),
    .avs_write(wr_a), .avs_writedata(wd_a), .avs_byteenable(be_a), .avs_readdata(rdd_a),
    .pio_out(pout_a), .pio_in(pin_a), .irq(irq_a)
  );

  avalon_pio_bank #(.NUM_CH(3), .DATA_W(12), .EDGE_MODE(2), .OUT_RESET(32'h0)) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(addr_b), .avs_read(rd_b),
    .avs_write(wr_b), .avs_writedata(wd_b), .avs_byteenable(be_b), .avs_readdata(rdd_b),
    .pio_out(pout_b), .pio_in(pin_b), .irq(irq_b)
  );

  // Reference model: register contents per configuration and channel.
  logic [31:0] m_out [2][4];
  logic [31:0] m_edge[2][4];
  logic [31:0] m_mask[2][4];
  logic [31:0] m_in  [2][4];
  int          nch[2]     = '{4, 3};
  logic [31:0] dmask[2]   = '{32'hFFFF_FFFF, 32'h0000_0FFF};
  int          mode[2]    = '{0, 2};
  logic [31:0] m_reset[2] = '{32'h0000_00FF, 32'h0};

  function automatic logic [31:0] bytemask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 4; c++) begin
        m_out[b][c] = m_reset[b]; m_edge[b][c] = 0; m_mask[b][c] = 0; m_in[b][c] = 0;
      end
  endtask

  task automatic model_write(input int b, input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] be);
    int ch = int'(addr) / 4;
    int r = int'(addr) % 4;
    logic [31:0] m = bytemask(be) & dmask[b];
    if (ch < nch[b]) begin
      if (r == 0) m_out[b][ch] = (m_out[b][ch] & ~m) | (data & m);
      if (r == 2) m_edge[b][ch] = m_edge[b][ch] & ~(data & m);
      if (r == 3) m_mask[b][ch] = (m_mask[b][ch] & ~m) | (data & m);
    end
  endtask

  function automatic logic [31:0] model_read(input int b, input logic [3:0] addr);
    int ch = int'(addr) / 4;
    int r = int'(addr) % 4;
    if (ch >= nch[b]) return 32'h0;
    case (r)
      0: return m_out[b][ch];
      1: return m_in[b][ch] & dmask[b];
      2: return m_edge[b][ch];
      default: return m_mask[b][ch];
    endcase
  endfunction

  function automatic logic [31:0] detect(input int b, input logic [31:0] o, input logic [31:0] n);
    if (mode[b] == 0) return n & ~o & dmask[b];
    if (mode[b] == 1) return ~n & o & dmask[b];
    return (n ^ o) & dmask[b];
  endfunction

  function automatic logic model_irq(input int b);
    logic r = 1'b0;
    for (int c = 0; c < nch[b]; c++) r = r | (|(m_edge[b][c] & m_mask[b][c]));
    return r;
  endfunction

  function automatic logic [31:0] get_out(input int b, input int ch);
    if (b == 1) return {20'h0, pout_b[ch*12 +: 12]};
    return pout_a[ch*32 +: 32];
  endfunction

  function automatic logic get_irq(input int b);
    return (b == 1) ? irq_b : irq_a;
  endfunction

  task automatic set_pin(input int b, input int ch, input logic [31:0] v);
    if (b == 1) pin_b[ch*12 +: 12] = v[11:0];
    else        pin_a[ch*32 +: 32] = v;
  endtask

  task automatic drive_bus(input int b, input logic rd, input logic wr, input logic [3:0] addr,
                           input logic [31:0] data, input logic [3:0] be);
    if (b == 1) begin rd_b = rd; wr_b = wr; addr_b = addr; wd_b = data; be_b = be; end
    else        begin rd_a = rd; wr_a = wr; addr_a = addr; wd_a = data; be_a = be; end
  endtask

  task automatic bus_write(input int b, input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
    @(negedge clk);
    drive_bus(b, 1'b0, 1'b1, addr, data, be);
    @(negedge clk);
    drive_bus(b, 1'b0, 1'b0, addr, 32'h0, 4'h0);
  endtask

  task automatic bus_read(input int b, input logic [3:0] addr, output logic [31:0] d);
    @(negedge clk);
    drive_bus(b, 1'b1, 1'b0, addr, 32'h0, 4'h0);
    @(negedge clk);
    drive_bus(b, 1'b0, 1'b0, addr, 32'h0, 4'h0);
    d = (b == 1) ? rdd_b : rdd_a;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    rst_n = 1'b0;
    pin_a = '0; pin_b = '0;
    drive_bus(0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    drive_bus(1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    model_reset();
    idle(3);
    total_cnt++;
    if (pout_a !== {4{32'h0000_00FF}}) $display("FAIL reset_pout_a got %h exp %h", pout_a, {4{32'h0000_00FF}});
    else pass_cnt++;
    total_cnt++;
    if (irq_a !== 1'b0 || irq_b !== 1'b0) $display("FAIL reset_irq got %b%b exp 00", irq_a, irq_b);
    else pass_cnt++;
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      bus_read(0, 4'(a), d);
      e = model_read(0, 4'(a));
      total_cnt++;
      if (d !== e) $display("FAIL reset_read addr=%0d got %h exp %h", a, d, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_byteenable();
    logic [31:0] d;
    bus_write(0, 4'd8, 32'hDEAD_BEEF, 4'b0011);
    model_write(0, 4'd8, 32'hDEAD_BEEF, 4'b0011);
    total_cnt++;
    if (get_out(0, 2) !== m_out[0][2]) $display("FAIL be_pout got %h exp %h", get_out(0, 2), m_out[0][2]);
    else pass_cnt++;
    bus_read(0, 4'd8, d);
    total_cnt++;
    if (d !== 32'h0000_BEEF) $display("FAIL be_read got %h exp %h", d, 32'h0000_BEEF);
    else pass_cnt++;
    bus_write(1, 4'd0, 32'hFFFF_FFFF, 4'hF);
    model_write(1, 4'd0, 32'hFFFF_FFFF, 4'hF);
    bus_read(1, 4'd0, d);
    total_cnt++;
    if (d !== 32'h0000_0FFF) $display("FAIL narrow_read got %h exp %h", d, 32'h0000_0FFF);
    else pass_cnt++;
    total_cnt++;
    if (get_out(1, 0) !== m_out[1][0]) $display("FAIL narrow_pout got %h exp %h", get_out(1, 0), m_out[1][0]);
    else pass_cnt++;
  endtask

  task automatic test_irq_timing();
    logic [31:0] d;
    bus_write(0, 4'd7, 32'h1, 4'hF);
    model_write(0, 4'd7, 32'h1, 4'hF);
    @(negedge clk);
    set_pin(0, 1, 32'h1);
    idle(2);
    total_cnt++;
    if (irq_a !== 1'b0) $display("FAIL irq_early2 got %b exp 0", irq_a); else pass_cnt++;
    idle(1);
    total_cnt++;
    if (irq_a !== 1'b0) $display("FAIL irq_early3 got %b exp 0", irq_a); else pass_cnt++;
    idle(1);
    total_cnt++;
    if (irq_a !== 1'b1) $display("FAIL irq_set got %b exp 1", irq_a); else pass_cnt++;
    m_edge[0][1] |= detect(0, m_in[0][1], 32'h1);
    m_in[0][1] = 32'h1;
    bus_read(0, 4'd6, d);
    total_cnt++;
    if (d !== m_edge[0][1]) $display("FAIL edge_c1 got %h exp %h", d, m_edge[0][1]); else pass_cnt++;
    @(negedge clk);
    drive_bus(0, 1'b0, 1'b1, 4'd6, 32'h1, 4'hF);
    @(negedge clk);
    drive_bus(0, 1'b0, 1'b0, 4'd6, 32'h0, 4'h0);
    model_write(0, 4'd6, 32'h1, 4'hF);
    total_cnt++;
    if (irq_a !== 1'b1) $display("FAIL irq_hold got %b exp 1", irq_a); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (irq_a !== model_irq(0)) $display("FAIL irq_clear got %b exp %b", irq_a, model_irq(0)); else pass_cnt++;
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    @(negedge clk);
    set_pin(0, 0, 32'h10);
    idle(2);
    drive_bus(0, 1'b0, 1'b1, 4'd2, 32'h10, 4'hF);
    @(negedge clk);
    drive_bus(0, 1'b0, 1'b0, 4'd2, 32'h0, 4'h0);
    model_write(0, 4'd2, 32'h10, 4'hF);
    m_edge[0][0] |= detect(0, m_in[0][0], 32'h10);
    m_in[0][0] = 32'h10;
    bus_read(0, 4'd2, d);
    total_cnt++;
    if (d !== m_edge[0][0]) $display("FAIL set_wins got %h exp %h", d, m_edge[0][0]); else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    logic [35:0] snap;
    snap = pout_b;
    bus_write(1, 4'd12, 32'h0000_0ABC, 4'hF);
    model_write(1, 4'd12, 32'h0000_0ABC, 4'hF);
    bus_read(1, 4'd12, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL oor_read got %h exp 0", d); else pass_cnt++;
    total_cnt++;
    if (pout_b !== snap) $display("FAIL oor_pout got %h exp %h", pout_b, snap); else pass_cnt++;
  endtask

  task automatic test_any_edge();
    logic [31:0] d;
    logic [31:0] vals[2] = '{32'h0A5, 32'h005};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_pin(1, 1, vals[i]);
      m_edge[1][1] |= detect(1, m_in[1][1], vals[i]);
      m_in[1][1] = vals[i];
      idle(4);
      bus_read(1, 4'd6, d);
      total_cnt++;
      if (d !== m_edge[1][1]) $display("FAIL any_edge step=%0d got %h exp %h", i, d, m_edge[1][1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_rw_same_cycle();
    logic [31:0] d, e;
    bus_write(0, 4'd15, 32'h0000_1234, 4'hF);
    model_write(0, 4'd15, 32'h0000_1234, 4'hF);
    e = model_read(0, 4'd15);
    @(negedge clk);
    drive_bus(0, 1'b1, 1'b1, 4'd15, 32'h0000_ABCD, 4'hF);
    @(negedge clk);
    drive_bus(0, 1'b0, 1'b0, 4'd15, 32'h0, 4'h0);
    model_write(0, 4'd15, 32'h0000_ABCD, 4'hF);
    total_cnt++;
    if (rdd_a !== e) $display("FAIL rw_old got %h exp %h", rdd_a, e); else pass_cnt++;
    bus_read(0, 4'd15, d);
    total_cnt++;
    if (d !== m_mask[0][3]) $display("FAIL rw_new got %h exp %h", d, m_mask[0][3]); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    bus_write(0, 4'd12, 32'h5, 4'hF);
    model_write(0, 4'd12, 32'h5, 4'hF);
    bus_write(0, 4'd7, 32'h2, 4'hF);
    model_write(0, 4'd7, 32'h2, 4'hF);
    @(negedge clk);
    set_pin(0, 1, m_in[0][1] | 32'h2);
    m_edge[0][1] |= detect(0, m_in[0][1], m_in[0][1] | 32'h2);
    m_in[0][1] = m_in[0][1] | 32'h2;
    idle(5);
    total_cnt++;
    if (irq_a !== model_irq(0) || irq_a !== 1'b1) $display("FAIL pre_reset_irq got %b exp 1", irq_a);
    else pass_cnt++;
    bus_read(0, 4'd12, d);
    total_cnt++;
    if (d !== 32'h5) $display("FAIL pre_reset_out got %h exp 5", d); else pass_cnt++;
    @(negedge clk);
    drive_bus(0, 1'b0, 1'b1, 4'd12, 32'h77, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (irq_a !== 1'b0) $display("FAIL async_irq got %b exp 0", irq_a); else pass_cnt++;
    total_cnt++;
    if (rdd_a !== 32'h0) $display("FAIL async_rdata got %h exp 0", rdd_a); else pass_cnt++;
    total_cnt++;
    if (get_out(0, 3) !== m_reset[0]) $display("FAIL async_out got %h exp %h", get_out(0, 3), m_reset[0]);
    else pass_cnt++;
    drive_bus(0, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    pin_a = '0; pin_b = '0;
    idle(2);
    rst_n = 1'b1;
    model_reset();
    bus_read(0, 4'd6, d);
    total_cnt++;
    if (d !== m_edge[0][1]) $display("FAIL post_reset_edge got %h exp %h", d, m_edge[0][1]); else pass_cnt++;
    bus_read(0, 4'd12, d);
    total_cnt++;
    if (d !== m_out[0][3]) $display("FAIL post_reset_out got %h exp %h", d, m_out[0][3]); else pass_cnt++;
    bus_read(0, 4'd7, d);
    total_cnt++;
    if (d !== m_mask[0][1]) $display("FAIL post_reset_mask got %h exp %h", d, m_mask[0][1]); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] d, e, nv, data;
    logic [3:0]  addr, be;
    int          op, ch;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 80; i++) begin
        op = $urandom_range(0, 2);
        if (op == 0) begin
          addr = 4'($urandom_range(0, 15));
          data = $urandom;
          be   = 4'($urandom_range(0, 15));
          bus_write(b, addr, data, be);
          model_write(b, addr, data, be);
        end else if (op == 1) begin
          addr = 4'($urandom_range(0, 15));
          bus_read(b, addr, d);
          e = model_read(b, addr);
          total_cnt++;
          if (d !== e) $display("FAIL rand_read cfg=%0d addr=%0d got %h exp %h", b, addr, d, e);
          else pass_cnt++;
          total_cnt++;
          if (get_irq(b) !== model_irq(b)) $display("FAIL rand_irq cfg=%0d got %b exp %b", b, get_irq(b), model_irq(b));
          else pass_cnt++;
        end else begin
          ch = $urandom_range(0, nch[b] - 1);
          nv = $urandom & dmask[b];
          set_pin(b, ch, nv);
          m_edge[b][ch] |= detect(b, m_in[b][ch], nv);
          m_in[b][ch] = nv;
          idle(4);
          total_cnt++;
          if (get_irq(b) !== model_irq(b)) $display("FAIL rand_pin_irq cfg=%0d got %b exp %b", b, get_irq(b), model_irq(b));
          else pass_cnt++;
        end
      end
      for (int c = 0; c < nch[b]; c++) begin
        total_cnt++;
        if (get_out(b, c) !== m_out[b][c]) $display("FAIL rand_pout cfg=%0d ch=%0d got %h exp %h", b, c, get_out(b, c), m_out[b][c]);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_byteenable();
    test_irq_timing();
    test_set_wins();
    test_out_of_range();
    test_any_edge();
    test_rw_same_cycle();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/avalon_pio_bank.md
Name: avalon_pio_bank

Overview:
Parametrised Avalon-MM slave that replaces the separate single-purpose PIO exports (keycode, hex digits, LEDs, key inputs) with one bank of NUM_CH channels. Each channel has:
- a DATA_W-bit output register;
- a synchronised DATA_W-bit input;
- per-bit edge capture and an interrupt mask.

It sits on the Nios II data bus inside the SoC. Its output and input vectors route to the game logic (VGA/tank control) and to board I/O.

Parameters:
NUM_CH, 4, number of channels (1..16)
DATA_W, 32, width of each channel's output, input and capture registers (1..32)
EDGE_MODE, 0, capture condition: 0 rising, 1 falling, 2 any edge
OUT_RESET, 0, reset value loaded into every output register
ADDR_W, clog2(NUM_CH)+2, derived; word address width

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
avs_address  in  ADDR_W  word address; {channel, reg}
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_byteenable  in  4  byte lanes for writes
avs_readdata  out  32  read data, valid one cycle after avs_read
pio_out  out  NUM_CH*DATA_W  output registers; channel c occupies bits [c*DATA_W +: DATA_W]
pio_in  in  NUM_CH*DATA_W  asynchronous inputs, same packing as pio_out
irq  out  1  level interrupt

Behaviour:
- Register map per channel c, word address c*4+r:
  - r0 OUT: RW.
  - r1 IN: RO, synchronised value.
  - r2 EDGE: capture bits; read, write-1-to-clear.
  - r3 MASK: RW interrupt enable.
- Bits above DATA_W:
  - read as 0;
  - writes to them are ignored.
- Reset (asynchronous, while reset_reset_n=0):
  - every OUT = OUT_RESET;
  - EDGE, MASK, synchroniser flops, avs_readdata = 0;
  - irq = 0.
- Reset asserted mid-transaction: the transaction is abandoned and no partial write remains.
- Input path:
  - two-flop synchroniser (s1, s2), plus a third flop s3 holding the previous value;
  - IN reads s2;
  - rising edge detect = s2 & ~s3; falling = ~s2 & s3; any = s2 ^ s3.
  - Latency pio_in change -> EDGE bit set: 3 clk_clk edges.
- EDGE update each cycle: EDGE <= (EDGE & ~clr) | det.
  - clr = avs_writedata masked by byteenable, when writing r2 of that channel.
  - Edge detection and W1C on the same bit in the same cycle: the set wins (bit stays 1).
- Writes to OUT and MASK: honour byteenable per byte lane. They take effect on the clock edge where avs_write=1.
- Writes to IN are ignored.
- Reads:
  - fixed read latency 1;
  - avs_readdata is registered on the cycle avs_read=1 and holds its value until the next read.
- Write and read of the same register in the same cycle: the read returns the pre-write value.
- No wait states; avs_read and avs_write are never stalled.
- Out-of-range channel (address channel field >= NUM_CH, possible when NUM_CH is not a power of 2):
  - reads return 0;
  - writes are ignored.
- irq = registered OR over all channels of (EDGE & MASK). It asserts 1 cycle after the contributing EDGE/MASK bit is set. It deasserts 1 cycle after it is cleared.
- pio_out is driven directly from the OUT registers, with zero combinational logic.

Decomposition:
- Shared package pio_pkg:
  - register offset constants REG_OUT=0, REG_IN=1, REG_EDGE=2, REG_MASK=3;
  - edge-mode enum EDGE_RISE/EDGE_FALL/EDGE_ANY;
  - clog2 helper function.
- One sub-module, pio_sync_edge, instantiated per channel:
  - parameters DATA_W and EDGE_MODE;
  - contains the s1/s2/s3 flops and the detector;
  - outputs sync_val and det.
- The top level holds the register file, the bus decode and irq.

Test Plan:
- Reset with OUT_RESET=32'h0000_00FF -> pio_out = {4{32'h0000_00FF}}, irq=0, all reads of r1..r3 return 0.
- Write c2 r0 (addr 8) data 32'hDEAD_BEEF, byteenable 4'b0011 -> pio_out channel 2 = 32'h0000_BEEF; the read one cycle later returns 32'h0000_BEEF.
- EDGE_MODE=0, MASK c1 = 32'h1, pio_in c1 bit0 0->1 -> EDGE c1 = 1 three cycles later, irq=1 one cycle after that. Write 32'h1 to addr 6 -> irq=0 two cycles after the write.
- Rising edge on c0 bit4 arriving in the same cycle as a W1C of 32'h10 to addr 2 -> EDGE c0 bit4 reads 1.
- NUM_CH=3, write to addr 12 then read addr 12 -> readdata 0 and no change on pio_out.
- Assert reset_reset_n=0 while irq=1 and OUT c3 = 32'h5 -> irq, EDGE and avs_readdata = 0 immediately (asynchronously), without waiting for a clock edge; OUT c3 returns to OUT_RESET.
